// File: rtl/ysyx_23060203_lsu.sv
// LSU: one memory op at a time, word-aligned request, load sign/zero extension; min 3-cycle accept-to-record, stalls on mem_req_ready/out_ready.
// YSYX_23060203_LSU_MISALIGN_TRAP_EN: misaligned/illegal accesses return an error record instead of being force-aligned.
module ysyx_23060203_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wen,
  input  logic [1:0]    in_size,
  input  logic          in_unsigned,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [4:0]    in_rd,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [3:0]    mem_wmask,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wen,
  output logic [4:0]    out_rd,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          wen_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_wmask_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] out_data_q;
  logic          out_wen_q;

  logic [1:0]    acc_size;
  logic [AW-1:0] eff_addr;
  logic [1:0]    acc_off;
  logic          acc_err;
  logic [3:0]    acc_mask;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] rsp_shift;
  logic [DW-1:0] ld_data;

  // Decode the offered op: legalise size/alignment and pre-compute lane data.
  always_comb begin
    acc_size = in_size;
    eff_addr = in_addr;
    acc_err  = 1'b0;
`ifdef YSYX_23060203_LSU_MISALIGN_TRAP_EN
    acc_err = (in_size == 2'd3) ||
              ((in_size == 2'd1) && in_addr[0]) ||
              ((in_size == 2'd2) && (in_addr[1:0] != 2'b00));
`else
    if (in_size == 2'd3) acc_size = 2'd2;
    if (acc_size == 2'd1) eff_addr[0] = 1'b0;
    if (acc_size == 2'd2) eff_addr[1:0] = 2'b00;
`endif
    acc_off = eff_addr[1:0];
    case (acc_size)
      2'd0:    acc_mask = 4'b0001 << acc_off;
      2'd1:    acc_mask = 4'b0011 << acc_off;
      default: acc_mask = 4'b1111;
    endcase
    if (!in_wen) acc_mask = 4'b0000;
    acc_wdata = in_wdata << {acc_off, 3'b000};
  end

  always_comb begin
    rsp_shift = mem_rsp_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = {{(DW-8){~uns_q & rsp_shift[7]}}, rsp_shift[7:0]};
      2'd1:    ld_data = {{(DW-16){~uns_q & rsp_shift[15]}}, rsp_shift[15:0]};
      default: ld_data = rsp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = acc_err ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_d = S_DONE;
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
      mem_addr_q  <= '0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= '0;
      out_data_q  <= '0;
      out_wen_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          wen_q       <= in_wen;
          size_q      <= acc_size;
          uns_q       <= in_unsigned;
          off_q       <= acc_off;
          rd_q        <= in_rd;
          mem_addr_q  <= {eff_addr[AW-1:2], 2'b00};
          mem_wmask_q <= acc_mask;
          mem_wdata_q <= acc_wdata;
          out_data_q  <= '0;
          out_wen_q   <= 1'b0;
        end
        S_WAIT: if (mem_rsp_valid && !wen_q) begin
          out_data_q <= ld_data;
          out_wen_q  <= (rd_q != 5'd0);
        end
        S_DONE: if (out_ready) out_wen_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef YSYX_23060203_LSU_MISALIGN_TRAP_EN
  logic out_err_q;
  always_ff @(posedge clk) begin
    if (rst) out_err_q <= 1'b0;
    else if (state_q == S_IDLE && in_valid) out_err_q <= acc_err;
    else if (state_q == S_DONE && out_ready) out_err_q <= 1'b0;
  end
  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = wen_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign out_wen   = out_wen_q;
  assign out_rd    = rd_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Directed bench for ysyx_23060203_lsu: loads, stores, backpressure, reset abandon, misalignment.
module tb_ysyx_23060203_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  ysyx_23060203_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen), .out_rd(out_rd),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_rd = rd;
    in_valid = 1'b1;
  endtask

  // Zero-wait load: accept at T, request T+1, response T+2, record T+3.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [31:0] exp_addr,
                         input logic [31:0] word, input logic [31:0] exp_data, input logic exp_wen);
    offer(1'b0, size, uns, addr, 32'h0, rd);
    mem_req_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick(); in_valid = 1'b0;
    chk({tag, "_req_valid"}, mem_req_valid, 1);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    tick();
    chk({tag, "_wait_req"}, mem_req_valid, 0);
    chk({tag, "_wait_out"}, out_valid, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = word;
    tick(); mem_rsp_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_data"}, out_data, exp_data);
    chk({tag, "_out_wen"}, out_wen, exp_wen);
    chk({tag, "_out_rd"}, out_rd, rd);
    chk({tag, "_out_err"}, out_err, 0);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk({tag, "_done_idle"}, in_ready, 1);
    chk({tag, "_done_out"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want 0x00000000 pending ops");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();

    do_load("lb_s",   32'h8000_0003, 2'd0, 1'b0, 5'd5, 32'h8000_0000, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1);
    do_load("lh_s",   32'h8000_0006, 2'd1, 1'b0, 5'd6, 32'h8000_0004, 32'h8123_4567, 32'hFFFF_8123, 1'b1);
    do_load("lbu",    32'h8000_0101, 2'd0, 1'b1, 5'd7, 32'h8000_0100, 32'h0000_AB00, 32'h0000_00AB, 1'b1);
    do_load("lhu",    32'h8000_0000, 2'd1, 1'b1, 5'd8, 32'h8000_0000, 32'h1234_F00D, 32'h0000_F00D, 1'b1);
    do_load("lw_x0",  32'h8000_0008, 2'd2, 1'b1, 5'd0, 32'h8000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // Stray response while idle must not start or complete anything.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
    tick(); mem_rsp_valid = 1'b0;
    chk("spur_in_ready", in_ready, 1);
    chk("spur_req_valid", mem_req_valid, 0);
    chk("spur_out_valid", out_valid, 0);

    // Store half, zero-wait.
    offer(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 5'd7);
    mem_req_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("sh_req_valid", mem_req_valid, 1);
    chk("sh_mem_addr", mem_addr, 32'h8000_0000);
    chk("sh_mem_wen", mem_wen, 1);
    chk("sh_mem_wmask", mem_wmask, 4'b1100);
    chk("sh_mem_wdata", mem_wdata, 32'hABCD_0000);
    tick();
    mem_rsp_valid = 1'b1;
    tick(); mem_rsp_valid = 1'b0;
    chk("sh_out_valid", out_valid, 1);
    chk("sh_out_wen", out_wen, 0);
    chk("sh_out_data", out_data, 0);
    chk("sh_out_rd", out_rd, 7);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;

    // Store byte under request and output backpressure.
    offer(1'b1, 2'd0, 1'b0, 32'h8000_0011, 32'h0000_005A, 5'd3);
    mem_req_ready = 1'b0;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_addr, 32'h8000_0010);
      chk("bp_mem_wmask", mem_wmask, 4'b0010);
      chk("bp_mem_wdata", mem_wdata, 32'h0000_5A00);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    chk("bp_req_hold", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick(); mem_req_ready = 1'b0;
    chk("bp_wait_req", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    tick(); mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_rd", out_rd, 3);
      chk("bp_in_ready_done", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_single_rec", out_valid, 0);
      chk("bp_idle", in_ready, 1);
      tick();
    end

    // Reset while waiting for the response; late response must be ignored.
    offer(1'b0, 2'd2, 1'b0, 32'h8000_0040, 32'h0, 5'd9);
    mem_req_ready = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk("rw_in_wait", mem_req_valid, 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1357_9BDF;
    tick(); mem_rsp_valid = 1'b0;
    tick();
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_req_valid", mem_req_valid, 0);
    chk("rw_out_wen", out_wen, 0);
    chk("rw_out_rd", out_rd, 0);
    chk("rw_out_data", out_data, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_wmask", mem_wmask, 0);
    chk("rw_mem_wdata", mem_wdata, 0);

`ifdef YSYX_23060203_LSU_MISALIGN_TRAP_EN
    offer(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 5'd9);
    mem_req_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mis_out_valid", out_valid, 1);
    chk("mis_out_err", out_err, 1);
    chk("mis_out_wen", out_wen, 0);
    chk("mis_out_data", out_data, 0);
    chk("mis_req_valid", mem_req_valid, 0);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("mis_idle", in_ready, 1);
    chk("mis_no_req", mem_req_valid, 0);
    chk("mis_err_clr", out_err, 0);
`else
    do_load("lw_mis", 32'h8000_0001, 2'd2, 1'b0, 5'd9, 32'h8000_0000, 32'h1122_3344, 32'h1122_3344, 1'b1);
    do_load("lw_sz3", 32'h8000_0022, 2'd3, 1'b0, 5'd4, 32'h8000_0020, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
